// File: rtl/shader_loader.sv
// shader_loader: SPI mode-0 (MSB first) program loader feeding the shader
// instruction memory. SPI pins are synchronised into clk_i, bytes are
// assembled and each finished byte is pushed as a one-cycle shift+load strobe.
// Optional feature macro: SHADER_LOADER_READBACK_EN streams the old memory
// head word back out on spi_miso_o while the new program is written.
module shader_loader #(
    parameter int NUM_INSTR   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         spi_sclk_i,
    input  logic                         spi_mosi_i,
    input  logic                         spi_cs_ni,
    output logic                         spi_miso_o,
    input  logic [7:0]                   mem_data_i,
    output logic                         shift_o,
    output logic                         load_o,
    output logic [7:0]                   instr_o,
    output logic                         busy_o,
    output logic [$clog2(NUM_INSTR)-1:0] word_cnt_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int CW = $clog2(NUM_INSTR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Synchroniser chains; the last stage is the clk_i-domain view of each pin.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;

    logic sclk_s, mosi_s, cs_s;

    // Previous synced levels and registered edge pulses. Registering the
    // edges adds one stage so the strobe lands SYNC_STAGES+2 cycles after
    // the raw edge is first sampled.
    logic sclk_prev_q, sclk_prev_d;
    logic cs_prev_q,   cs_prev_d;
    logic sclk_rise_q, sclk_rise_d;
    logic sclk_fall_q, sclk_fall_d;
    logic cs_rise_q,   cs_rise_d;
    logic cs_fall_q,   cs_fall_d;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic [CW-1:0]   word_cnt_inc;
    logic [7:0]      sreg_q, sreg_d;
    logic            cs_seen_q, cs_seen_d;
    logic            shift_q, shift_d;
    logic [7:0]      instr_q, instr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    // Synchroniser shifting and edge detection against the prior synced level.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_ni};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise_d = sclk_s & ~sclk_prev_q;
        sclk_fall_d = ~sclk_s & sclk_prev_q;
        cs_rise_d   = cs_s & ~cs_prev_q;
        cs_fall_d   = ~cs_s & cs_prev_q;
    end

    // Word counter increment wrapping at the memory depth.
    always_comb begin
        if (word_cnt_q == CW'(NUM_INSTR - 1)) begin
            word_cnt_inc = '0;
        end else begin
            word_cnt_inc = word_cnt_q + 1'b1;
        end
    end

    // Loader FSM: next state, datapath updates and strobe/status outputs.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        sreg_d     = sreg_q;
        cs_seen_d  = cs_seen_q;
        shift_d    = 1'b0;
        instr_d    = instr_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d    = RECV;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    sreg_d     = '0;
                    cs_seen_d  = 1'b0;
                    err_d      = 1'b0;
                end
            end
            RECV: begin
                if (sclk_rise_q && bit_cnt_q == 3'd7) begin
                    // Last bit of a byte: commit it even if cs rises now,
                    // remembering the cs rise for after the commit.
                    sreg_d    = {sreg_q[6:0], mosi_s};
                    bit_cnt_d = '0;
                    cs_seen_d = cs_rise_q;
                    state_d   = COMMIT;
                end else begin
                    if (sclk_rise_q) begin
                        sreg_d    = {sreg_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (cs_rise_q) begin
                        state_d = IDLE;
                        if (bit_cnt_d != 3'd0 || word_cnt_q != '0) begin
                            err_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            COMMIT: begin
                shift_d    = 1'b1;
                instr_d    = sreg_q;
                word_cnt_d = word_cnt_inc;
                cs_seen_d  = 1'b0;
                if (cs_seen_q || cs_rise_q) begin
                    state_d = IDLE;
                    if (word_cnt_inc != '0) begin
                        err_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Single register bank for synchronisers, edges, FSM and outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            sreg_q      <= '0;
            cs_seen_q   <= 1'b0;
            shift_q     <= 1'b0;
            instr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            sreg_q      <= sreg_d;
            cs_seen_q   <= cs_seen_d;
            shift_q     <= shift_d;
            instr_q     <= instr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign shift_o    = shift_q;
    assign load_o     = shift_q;
    assign instr_o    = instr_q;
    assign busy_o     = busy_q;
    assign word_cnt_o = word_cnt_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

`ifdef SHADER_LOADER_READBACK_EN
    logic [7:0] rb_q, rb_d;

    // Readback register: reload from the memory head at transfer start and
    // at each commit, shift out MSB first on sclk falls within a byte. The
    // fall following the 8th rise is skipped (bit_cnt is back at 0) so the
    // freshly loaded word keeps its MSB for the next byte.
    always_comb begin
        rb_d = rb_q;
        if (state_q == IDLE && cs_fall_q) begin
            rb_d = mem_data_i;
        end else if (state_q == COMMIT) begin
            rb_d = mem_data_i;
        end else if (state_q == RECV && sclk_fall_q && bit_cnt_q != 3'd0) begin
            rb_d = {rb_q[6:0], 1'b0};
        end
    end

    // Readback register storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rb_q <= '0;
        end else begin
            rb_q <= rb_d;
        end
    end

    assign spi_miso_o = rb_q[7] & (state_q != IDLE);
`else
    logic rb_unused;

    assign rb_unused  = ^{mem_data_i, sclk_fall_q};
    assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_shader_loader.sv
// Directed testbench for shader_loader: drives SPI transfers, records the
// strobes the DUT issues and compares them with hand-computed values.
module tb_shader_loader;

    localparam int NUM_INSTR   = 8;
    localparam int SYNC_STAGES = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       spi_sclk_i;
    logic       spi_mosi_i;
    logic       spi_cs_ni;
    logic       spi_miso_o;
    logic [7:0] mem_data_i;
    logic       shift_o;
    logic       load_o;
    logic [7:0] instr_o;
    logic       busy_o;
    logic [2:0] word_cnt_o;
    logic       done_o;
    logic       err_o;

    int checks   = 0;
    int failures = 0;

    int unsigned cyc = 0;
    int          done_cnt = 0;
    int          load_skew = 0;
    int          miso_high = 0;
    int          s_base;
    int          d_base;
    logic [7:0]  miso_cap = 8'h00;

    logic [7:0]  strobe_data[$];
    int unsigned shift_cyc[$];
    int unsigned rise_cyc[$];

    logic [7:0]  prog[8] = '{8'h10, 8'h15, 8'h74, 8'h1A, 8'h98, 8'h00, 8'h40, 8'h40};

    shader_loader #(
        .NUM_INSTR   (NUM_INSTR),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .spi_sclk_i (spi_sclk_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_cs_ni  (spi_cs_ni),
        .spi_miso_o (spi_miso_o),
        .mem_data_i (mem_data_i),
        .shift_o    (shift_o),
        .load_o     (load_o),
        .instr_o    (instr_o),
        .busy_o     (busy_o),
        .word_cnt_o (word_cnt_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    // 100 MHz system clock.
    always #5 clk_i = ~clk_i;

    // Free-running cycle counter used to measure strobe latency.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: record every strobe and done pulse, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (shift_o === 1'b1) begin
            strobe_data.push_back(instr_o);
            shift_cyc.push_back(cyc);
        end
        if (shift_o !== load_o) load_skew++;
        if (done_o === 1'b1) done_cnt++;
        if (spi_miso_o !== 1'b0) miso_high++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Send the top nbits of a byte, MSB first, 4-cycle sclk half periods.
    // With cs_end set, cs rises together with the last sclk rise.
    task automatic applyStimulus(input logic [7:0] b, input int nbits, input bit cs_end);
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi_i = b[i];
            waitCycles(4);
            miso_cap = {miso_cap[6:0], spi_miso_o};
            spi_sclk_i = 1'b1;
            if (i == 0) begin
                rise_cyc.push_back(cyc);
                if (cs_end) spi_cs_ni = 1'b1;
            end
            waitCycles(4);
            spi_sclk_i = 1'b0;
        end
    endtask

    task automatic csLow();
        spi_cs_ni = 1'b0;
        waitCycles(4);
    endtask

    task automatic csHigh();
        spi_cs_ni = 1'b1;
        waitCycles(10);
    endtask

    task automatic clearLog();
        strobe_data.delete();
        shift_cyc.delete();
        rise_cyc.delete();
    endtask

    initial begin
        rst_i      = 1'b1;
        spi_sclk_i = 1'b0;
        spi_mosi_i = 1'b0;
        spi_cs_ni  = 1'b1;
        mem_data_i = 8'hC3;
        waitCycles(3);
        checkOutput("rst_shift", {31'd0, shift_o}, 0);
        checkOutput("rst_instr", {24'd0, instr_o}, 0);
        checkOutput("rst_busy", {31'd0, busy_o}, 0);
        checkOutput("rst_done_err", {30'd0, done_o, err_o}, 0);
        checkOutput("rst_miso", {31'd0, spi_miso_o}, 0);
        rst_i = 1'b0;
        waitCycles(4);

        $display("[TB] reset in the middle of a byte");
        csLow();
        applyStimulus(8'hA5, 4, 1'b0);
        checkOutput("mid_busy", {31'd0, busy_o}, 1);
        rst_i     = 1'b1;
        spi_cs_ni = 1'b1;
        waitCycles(2);
        rst_i = 1'b0;
        checkOutput("mid_rst_busy", {31'd0, busy_o}, 0);
        checkOutput("mid_rst_wcnt", {29'd0, word_cnt_o}, 0);
        checkOutput("mid_rst_err", {31'd0, err_o}, 0);
        waitCycles(8);
        checkOutput("mid_rst_nostrobe", strobe_data.size(), 0);

        $display("[TB] single byte 0x5A after reset");
        d_base = done_cnt;
        csLow();
        applyStimulus(8'h5A, 8, 1'b0);
        csHigh();
        checkOutput("one_strobes", strobe_data.size(), 1);
        checkOutput("one_data", {24'd0, strobe_data[0]}, 32'h5A);
        checkOutput("one_wcnt", {29'd0, word_cnt_o}, 1);
        checkOutput("one_err", {31'd0, err_o}, 1);
        checkOutput("one_nodone", done_cnt - d_base, 0);

        $display("[TB] full 8-word program");
        clearLog();
        d_base = done_cnt;
        csLow();
        checkOutput("full_err_cleared", {31'd0, err_o}, 0);
        for (int i = 0; i < 8; i++) applyStimulus(prog[i], 8, 1'b0);
        csHigh();
        checkOutput("full_strobes", strobe_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("full_data%0d", i), {24'd0, strobe_data[i]}, {24'd0, prog[i]});
        end
        // Rise driven at negedge k is first sampled at posedge k+1; the
        // strobe must follow SYNC_STAGES+2 edges later, seen at negedge k+5.
        checkOutput("full_latency0", shift_cyc[0] - rise_cyc[0], SYNC_STAGES + 3);
        checkOutput("full_latency7", shift_cyc[7] - rise_cyc[7], SYNC_STAGES + 3);
        checkOutput("full_done", done_cnt - d_base, 1);
        checkOutput("full_err", {31'd0, err_o}, 0);
        checkOutput("full_wcnt", {29'd0, word_cnt_o}, 0);
        checkOutput("full_busy", {31'd0, busy_o}, 0);
        checkOutput("full_instr_hold", {24'd0, instr_o}, 32'h40);

        $display("[TB] partial byte then zero-byte transfer");
        s_base = strobe_data.size();
        d_base = done_cnt;
        csLow();
        applyStimulus(8'hFF, 5, 1'b0);
        csHigh();
        checkOutput("part_nostrobe", strobe_data.size() - s_base, 0);
        checkOutput("part_err", {31'd0, err_o}, 1);
        checkOutput("part_nodone", done_cnt - d_base, 0);
        csLow();
        checkOutput("zero_err_cleared", {31'd0, err_o}, 0);
        checkOutput("zero_busy", {31'd0, busy_o}, 1);
        csHigh();
        checkOutput("zero_done", done_cnt - d_base, 1);
        checkOutput("zero_err", {31'd0, err_o}, 0);
        checkOutput("zero_nostrobe", strobe_data.size() - s_base, 0);

        $display("[TB] short 3-byte program");
        clearLog();
        d_base = done_cnt;
        csLow();
        applyStimulus(8'h11, 8, 1'b0);
        applyStimulus(8'h22, 8, 1'b0);
        applyStimulus(8'h33, 8, 1'b0);
        csHigh();
        checkOutput("short_strobes", strobe_data.size(), 3);
        checkOutput("short_data2", {24'd0, strobe_data[2]}, 32'h33);
        checkOutput("short_wcnt", {29'd0, word_cnt_o}, 3);
        checkOutput("short_err", {31'd0, err_o}, 1);
        checkOutput("short_nodone", done_cnt - d_base, 0);

        $display("[TB] cs rise coincident with 8th sclk rise, 8 words");
        clearLog();
        d_base = done_cnt;
        csLow();
        for (int i = 0; i < 7; i++) applyStimulus(prog[i], 8, 1'b0);
        applyStimulus(8'hE7, 8, 1'b1);
        waitCycles(10);
        checkOutput("coin8_strobes", strobe_data.size(), 8);
        checkOutput("coin8_last", {24'd0, strobe_data[7]}, 32'hE7);
        checkOutput("coin8_done", done_cnt - d_base, 1);
        checkOutput("coin8_err", {31'd0, err_o}, 0);
        checkOutput("coin8_wcnt", {29'd0, word_cnt_o}, 0);
        checkOutput("coin8_busy", {31'd0, busy_o}, 0);

        $display("[TB] cs rise coincident with 8th sclk rise, 2 words");
        clearLog();
        d_base = done_cnt;
        csLow();
        applyStimulus(8'h3C, 8, 1'b0);
        applyStimulus(8'h81, 8, 1'b1);
        waitCycles(10);
        checkOutput("coin2_strobes", strobe_data.size(), 2);
        checkOutput("coin2_last", {24'd0, strobe_data[1]}, 32'h81);
        checkOutput("coin2_err", {31'd0, err_o}, 1);
        checkOutput("coin2_nodone", done_cnt - d_base, 0);
        checkOutput("coin2_wcnt", {29'd0, word_cnt_o}, 2);

        $display("[TB] sclk activity with cs high");
        s_base = strobe_data.size();
        applyStimulus(8'hFF, 8, 1'b0);
        waitCycles(8);
        checkOutput("csh_nostrobe", strobe_data.size() - s_base, 0);
        checkOutput("csh_busy", {31'd0, busy_o}, 0);
        checkOutput("load_skew", load_skew, 0);

`ifdef SHADER_LOADER_READBACK_EN
        $display("[TB] readback of memory head 0xC3");
        mem_data_i = 8'hC3;
        csLow();
        applyStimulus(8'h00, 8, 1'b0);
        csHigh();
        checkOutput("rb_bits", {24'd0, miso_cap}, 32'hC3);
        checkOutput("rb_idle_miso", {31'd0, spi_miso_o}, 0);
`else
        checkOutput("miso_tied_low", miso_high, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
